// File: rtl/regfile_wb_queue_if.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue_if
//   Bundles the producer push handshake and the register-file write port of
//   the write-back queue.
//
//   Producer side : in_valid, in_ready, in_wa[3:0], in_wd[31:0]
//   Regfile side  : WA[3:0], WD[31:0], RegWrite
//
//   Handshake: a transfer happens at a rising edge where in_valid and
//   in_ready are both 1. in_valid/in_wa/in_wd are held by the producer until
//   accepted. in_ready may depend combinationally on the drain decision in
//   the same cycle, but never on in_valid.
//
//   modport master : result producer / register file (test environment)
//   modport slave  : the queue itself
// -----------------------------------------------------------------------------
interface regfile_wb_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_wa;
  logic [31:0] in_wd;
  logic [3:0]  WA;
  logic [31:0] WD;
  logic        RegWrite;

  modport master (
    output in_valid, in_wa, in_wd,
    input  in_ready, WA, WD, RegWrite
  );

  modport slave (
    input  in_valid, in_wa, in_wd,
    output in_ready, WA, WD, RegWrite
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// regfile_wb_queue
//   Write-back buffer in front of the 16x32 register file write port.
//   Producers push {wa, wd} pairs; the head drains one entry per cycle into
//   the register file in arrival order. A per-register busy vector flags
//   registers that still have a queued write.
//
//   Parameters : DEPTH   number of entries, power of two, 2..16
//   Ports      : clk     rising-edge clock
//                rst_n   synchronous reset, active low
//                bus     regfile_wb_queue_if.slave (push handshake + WA/WD/RegWrite)
//                wb_en   drain enable, 0 freezes the head
//                busy    bit r set while a queued entry targets register r
//                count   occupied entries
//                full    count == DEPTH
//                empty   count == 0
//
//   Optional feature: define REGFILE_WB_BYPASS_EN to forward an incoming
//   result straight to the register file when the queue is empty and
//   draining (0-cycle latency, not enqueued, never marked busy).
// -----------------------------------------------------------------------------
module regfile_wb_queue #(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  regfile_wb_queue_if.slave            bus,
  input  logic                         wb_en,
  output logic [15:0]                  busy,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [3:0]    wa_mem [DEPTH];
  logic [31:0]   wd_mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;

  logic push;
  logic pop;
  logic bypass;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));
  assign count = count_q;

  // Nothing reaches the register file during a reset cycle, so entries being
  // discarded (or a result arriving alongside reset) are never written.
  assign pop = rst_n && wb_en && !empty;

`ifdef REGFILE_WB_BYPASS_EN
  assign bypass = rst_n && empty && wb_en && bus.in_valid;
`else
  assign bypass = 1'b0;
`endif

  // A full queue still accepts when the head leaves in the same cycle.
  assign bus.in_ready = !full || pop;
  assign push         = rst_n && bus.in_valid && bus.in_ready && !bypass;

  // Register-file write port: bypassed input, else head entry, else zero.
  always_comb begin
    bus.WA = '0;
    bus.WD = '0;
    if (bypass) begin
      bus.WA = bus.in_wa;
      bus.WD = bus.in_wd;
    end else if (!empty) begin
      bus.WA = wa_mem[rd_ptr];
      bus.WD = wd_mem[rd_ptr];
    end
  end

  assign bus.RegWrite = pop || bypass;

  // Entry i positions after the head is valid while i < count; duplicates
  // simply OR into the same bit.
  always_comb begin
    busy = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        busy[wa_mem[rd_ptr + AW'(i)]] = 1'b1;
      end
    end
  end

  // Storage is left unreset; count/pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem[wr_ptr] <= bus.in_wa;
      wd_mem[wr_ptr] <= bus.in_wd;
    end
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_wb_queue.sv
// -----------------------------------------------------------------------------
// tb_regfile_wb_queue
//   Directed bench for regfile_wb_queue (DEPTH = 4, default build without
//   forwarding). A table of per-cycle input/expected-output records covers
//   reset, ordering with duplicates, full, full with simultaneous push/pop
//   and reset mid-operation; a hand-written loop streams back-to-back
//   traffic across the pointer wrap. Every register-file write is also
//   matched against an expected queue of accepted pushes.
// -----------------------------------------------------------------------------
module tb_regfile_wb_queue;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst_n;
  logic        wb_en;
  logic [15:0] busy;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  regfile_wb_queue_if bus ();

  regfile_wb_queue #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .wb_en (wb_en),
    .busy  (busy),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // ---------------------------------------------------------------- clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- vectors
  typedef struct {
    logic        rst_n;
    logic        in_valid;
    logic        wb_en;
    logic [3:0]  in_wa;
    logic [31:0] in_wd;
    logic        rdy;
    logic        rw;
    logic [3:0]  wa;
    logic [31:0] wd;
    logic [15:0] busy;
    logic [2:0]  cnt;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic v, input logic w,
                              input logic [3:0] iwa, input logic [31:0] iwd,
                              input logic rdy, input logic rw,
                              input logic [3:0] ewa, input logic [31:0] ewd,
                              input logic [15:0] eb, input logic [2:0] ec);
    vec_t t;
    t.rst_n = r;   t.in_valid = v; t.wb_en = w;
    t.in_wa = iwa; t.in_wd = iwd;
    t.rdy = rdy;   t.rw = rw;      t.wa = ewa; t.wd = ewd;
    t.busy = eb;   t.cnt = ec;
    return t;
  endfunction

  // ---------------------------------------------------------------- scoreboard
  logic [35:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // One cycle: drive after the rising edge, check at the falling edge,
  // then record what the coming edge accepts.
  task automatic run_cycle(input vec_t t, input string tag, input int idx);
    logic [35:0] head;
    rst_n        = t.rst_n;
    bus.in_valid = t.in_valid;
    wb_en        = t.wb_en;
    bus.in_wa    = t.in_wa;
    bus.in_wd    = t.in_wd;
    @(negedge clk);
    chk({tag, " in_ready"}, idx, 32'(bus.in_ready), 32'(t.rdy));
    chk({tag, " RegWrite"}, idx, 32'(bus.RegWrite), 32'(t.rw));
    chk({tag, " WA"},       idx, 32'(bus.WA),       32'(t.wa));
    chk({tag, " WD"},       idx, bus.WD,            t.wd);
    chk({tag, " busy"},     idx, 32'(busy),         32'(t.busy));
    chk({tag, " count"},    idx, 32'(count),        32'(t.cnt));
    chk({tag, " full"},     idx, 32'(full),         32'(t.cnt == 3'(DEPTH)));
    chk({tag, " empty"},    idx, 32'(empty),        32'(t.cnt == 3'd0));
    if (bus.RegWrite === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s step %0d sb_write: got write %h<-%h expected none",
                 tag, idx, bus.WA, bus.WD);
      end else begin
        head = exp_q.pop_front();
        chk({tag, " sb_write"}, idx, {bus.WD}, head[31:0]);
        chk({tag, " sb_addr"},  idx, 32'(bus.WA), 32'(head[35:32]));
      end
    end
    if (!t.rst_n)
      exp_q.delete();
    else if (t.in_valid && t.rdy)
      exp_q.push_back({t.in_wa, t.in_wd});
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------- test
  initial begin
    logic [3:0]  prev_wa;
    logic [31:0] prev_wd;
    logic [3:0]  nwa;
    logic [31:0] nwd;

    rst_n        = 1'b0;
    wb_en        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_wa    = 4'd3;
    bus.in_wd    = 32'hDEADBEEF;
    @(posedge clk);
    #1;

    //            rst v  wb wa    wd            rdy rw wa    wd            busy       cnt
    // reset held with in_valid = 1
    vecs.push_back(mk(0, 1, 1, 4'd3, 32'hDEADBEEF, 1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    vecs.push_back(mk(0, 1, 1, 4'd3, 32'hDEADBEEF, 1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    // first push, written one cycle later
    vecs.push_back(mk(1, 1, 1, 4'd3, 32'hDEADBEEF, 1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h0,        1, 1, 4'd3, 32'hDEADBEEF, 16'h0008, 3'd1));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,        1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    // ordering with duplicate destinations, drain frozen
    vecs.push_back(mk(1, 1, 0, 4'd5, 32'd1,        1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    vecs.push_back(mk(1, 1, 0, 4'd5, 32'd2,        1, 0, 4'd5, 32'd1,        16'h0020, 3'd1));
    vecs.push_back(mk(1, 1, 0, 4'd7, 32'd3,        1, 0, 4'd5, 32'd1,        16'h0020, 3'd2));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,        1, 0, 4'd5, 32'd1,        16'h00A0, 3'd3));
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h0,        1, 1, 4'd5, 32'd1,        16'h00A0, 3'd3));
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h0,        1, 1, 4'd5, 32'd2,        16'h00A0, 3'd2));
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h0,        1, 1, 4'd7, 32'd3,        16'h0080, 3'd1));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,        1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    // fill to DEPTH, then a refused fifth push
    vecs.push_back(mk(1, 1, 0, 4'd1, 32'h11,       1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    vecs.push_back(mk(1, 1, 0, 4'd2, 32'h22,       1, 0, 4'd1, 32'h11,       16'h0002, 3'd1));
    vecs.push_back(mk(1, 1, 0, 4'd3, 32'h33,       1, 0, 4'd1, 32'h11,       16'h0006, 3'd2));
    vecs.push_back(mk(1, 1, 0, 4'd4, 32'h44,       1, 0, 4'd1, 32'h11,       16'h000E, 3'd3));
    vecs.push_back(mk(1, 1, 0, 4'd6, 32'h66,       0, 0, 4'd1, 32'h11,       16'h001E, 3'd4));
    vecs.push_back(mk(1, 1, 0, 4'd6, 32'h66,       0, 0, 4'd1, 32'h11,       16'h001E, 3'd4));
    // full with simultaneous push and pop
    vecs.push_back(mk(1, 1, 1, 4'd6, 32'h66,       1, 1, 4'd1, 32'h11,       16'h001E, 3'd4));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,        0, 0, 4'd2, 32'h22,       16'h005C, 3'd4));
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h0,        1, 1, 4'd2, 32'h22,       16'h005C, 3'd4));
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h0,        1, 1, 4'd3, 32'h33,       16'h0058, 3'd3));
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h0,        1, 1, 4'd4, 32'h44,       16'h0050, 3'd2));
    vecs.push_back(mk(1, 0, 1, 4'd0, 32'h0,        1, 1, 4'd6, 32'h66,       16'h0040, 3'd1));
    vecs.push_back(mk(1, 0, 0, 4'd0, 32'h0,        1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    // reset mid-operation with three entries queued
    vecs.push_back(mk(1, 1, 0, 4'd8,  32'h81,      1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    vecs.push_back(mk(1, 1, 0, 4'd9,  32'h91,      1, 0, 4'd8, 32'h81,       16'h0100, 3'd1));
    vecs.push_back(mk(1, 1, 0, 4'd10, 32'hA1,      1, 0, 4'd8, 32'h81,       16'h0300, 3'd2));
    vecs.push_back(mk(0, 1, 0, 4'd11, 32'hB1,      1, 0, 4'd8, 32'h81,       16'h0700, 3'd3));
    vecs.push_back(mk(1, 0, 1, 4'd0,  32'h0,       1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));
    vecs.push_back(mk(1, 0, 1, 4'd0,  32'h0,       1, 0, 4'd0, 32'h0,        16'h0000, 3'd0));

    foreach (vecs[i]) run_cycle(vecs[i], "vec", i);

    // Back-to-back stream across the pointer wrap: one write every cycle
    // after the first, each showing the previous push.
    prev_wa = '0;
    prev_wd = '0;
    for (int i = 0; i < 10; i++) begin
      nwa = 4'($urandom_range(0, 15));
      nwd = $urandom;
      if (i == 0)
        run_cycle(mk(1, 1, 1, nwa, nwd, 1, 0, 4'd0, 32'h0, 16'h0000, 3'd0), "wrap", i);
      else
        run_cycle(mk(1, 1, 1, nwa, nwd, 1, 1, prev_wa, prev_wd,
                     16'(1) << prev_wa, 3'd1), "wrap", i);
      prev_wa = nwa;
      prev_wd = nwd;
    end
    run_cycle(mk(1, 0, 1, 4'd0, 32'h0, 1, 1, prev_wa, prev_wd, 16'(1) << prev_wa, 3'd1), "wrap", 10);
    run_cycle(mk(1, 0, 1, 4'd0, 32'h0, 1, 0, 4'd0, 32'h0, 16'h0000, 3'd0), "wrap", 11);

    chk("drained", 0, 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
# regfile_wb_queue

Write-back buffer that sits in front of the 16x32 register file's single write port and is the sole driver of its WA/WD/RegWrite inputs. Result producers (ALU, load unit, multi-cycle multiplier/MLA) push {destination, data} pairs through a valid/ready handshake. The queue drains at most one entry per cycle into the register file in arrival order. It also exports a per-register pending-write scoreboard that hazard logic uses to stall RD1/RD2/RD3 consumers.

## Interface
- DEPTH, 4, number of queue entries; power of two, 2..16
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous reset, active low
- in_valid  input  1  producer has a result
- in_ready  output  1  queue can accept this cycle
- in_wa  input  4  destination register index
- in_wd  input  32  result data
- wb_en  input  1  drain enable; 0 holds the head (pipeline freeze)
- WA  output  4  register-file write address
- WD  output  32  register-file write data
- RegWrite  output  1  register-file write strobe
- busy  output  16  bit r = 1 while any queued entry targets register r
- count  output  $clog2(DEPTH+1)  occupied entries
- full  output  1  count == DEPTH
- empty  output  1  count == 0

## Operation
- Storage: DEPTH entries of {wa[3:0], wd[31:0]}, circular buffer with rd_ptr/wr_ptr that wrap modulo DEPTH, plus a count register.
- Push: in_valid && in_ready at a rising edge writes the entry at wr_ptr, then wr_ptr++.
- in_ready = !full || pop. A push into a full queue is accepted when the head drains in the same cycle.
- Pop: pop = wb_en && !empty. WA/WD are driven combinationally from the head entry. RegWrite = pop. rd_ptr++ at the edge.
- When RegWrite = 0, WA and WD still show the head entry, or 0 when empty.
- Count update per edge: push only gives +1; pop only gives −1; push and pop together leave it unchanged.
- busy: OR over valid entries of the one-hot of wa, computed combinationally from the storage contents. Duplicate destinations are allowed and stay in FIFO order, so the last write wins in the register file.
- No coalescing, no reordering, no special handling of register 15.
- Reset (rst_n = 0 at an edge): pointers and count go to 0, so empty = 1, full = 0, busy = 0, RegWrite = 0, WA = 0, WD = 0, in_ready = 1. Entries in flight are discarded, and a push in the reset cycle is ignored.

## Timing
- Without bypass:
  - A push accepted at edge k is visible at the head during cycle k+1 if the queue was empty.
  - The register file writes it at edge k+1.
  - Minimum latency is 1 cycle.
- Throughput: 1 push and 1 pop per cycle, sustained.
- busy[r] rises in the cycle after the accepting edge. It falls in the cycle after the last entry with wa = r pops.
- wb_en = 0: no pops. Pushes continue until full, then in_ready = 0.
- Wrap-around: pointers roll from DEPTH−1 to 0 with no bubble.

## Configuration
- REGFILE_WB_BYPASS_EN defined:
  - When empty && wb_en && in_valid, the input is forwarded combinationally (WA = in_wa, WD = in_wd, RegWrite = 1) and is not enqueued. The register file writes at the accepting edge, giving 0-cycle latency.
  - busy does not assert for a bypassed entry.
- REGFILE_WB_BYPASS_EN undefined: every accepted entry is enqueued, with 1-cycle minimum latency as above.

## Test plan
- Reset: hold rst_n = 0 with in_valid = 1 for 2 cycles. Required response: RegWrite = 0, empty = 1, busy = 16'h0000, count = 0. After release, first push {3, 32'hDEADBEEF} results in RegWrite = 1, WA = 3, WD = 32'hDEADBEEF one cycle later (same cycle with bypass).
- Ordering/duplicates: with wb_en = 0, push {5, 1}, {5, 2}, {7, 3}. Required response: busy = 16'h00A0, count = 3. Then set wb_en = 1: writes occur in order 5←1, 5←2, 7←3. busy[5] clears after the second pop, busy[7] after the third.
- Full: with wb_en = 0, push DEPTH = 4 entries. Required response: full = 1, in_ready = 0, and a fifth in_valid is not accepted (count stays 4).
- Full with simultaneous push and pop: on the cycle wb_en goes to 1 with in_valid = 1, in_ready = 1. The head pops, the new entry is accepted, and count stays 4.
- Wrap-around: stream 10 back-to-back pushes with wb_en = 1. Required response: 10 consecutive RegWrite pulses with no bubble and data matching inputs in order.
- Reset mid-operation: fill 3 entries, then pulse rst_n = 0 for one cycle. Required response: count = 0, busy = 0, and none of the discarded entries is ever written.
